// File: rtl/bw_mult_pkg.sv
// rtl/bw_mult_pkg.sv - shared types and constants for the Baugh-Wooley multiplier
//
// Purpose: FSM state type, cycle-count helper and correction-constant helper
//          used by bw_mult_seq and its row generator.
// Ports:   none (package).
package bw_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Wide enough for any practical accumulator; callers truncate to their width.
  localparam int CORR_MAX_W = 128;

  // Number of RUN cycles needed to sum WIDTH+1 rows at rows_per_cyc per cycle.
  function automatic int ncyc(input int width, input int rows_per_cyc);
    return (width + 1 + rows_per_cyc - 1) / rows_per_cyc;
  endfunction

  // Baugh-Wooley correction constant for a we x we signed multiply:
  // 2^we + 2^(2*we-1), which folds in the constants produced by the inverted sign terms.
  function automatic logic [CORR_MAX_W-1:0] bw_corr(input int we);
    logic [CORR_MAX_W-1:0] one;
    one = CORR_MAX_W'(1);
    return (one << we) + (one << (2 * we - 1));
  endfunction

endpackage

// File: rtl/bw_pp_row.sv
// rtl/bw_pp_row.sv - one shifted, inversion-corrected Baugh-Wooley partial-product row
//
// Purpose: combinational generator of partial-product row `row`, already shifted
//          into accumulator alignment. Rows at or beyond WE produce zero so the
//          top can over-run the row count on the final cycle.
// Ports:
//   a_ext    in   WE       sign/zero-extended multiplicand
//   b_bit    in   1        multiplier bit selected for this row
//   row      in   IDX_W    row index
//   row_val  out  2*WE     shifted row, ready to add into the accumulator
module bw_pp_row
  import bw_mult_pkg::*;
#(
  parameter int WE    = 9,
  parameter int IDX_W = 4
) (
  input  logic [WE-1:0]   a_ext,
  input  logic            b_bit,
  input  logic [IDX_W-1:0] row,
  output logic [2*WE-1:0] row_val
);

  logic [WE-1:0] pp;
  logic          last_row;

  always_comb begin
    pp       = '0;
    last_row = (row == IDX_W'(WE - 1));
    // Invert a bit when exactly one of (column, row) is the sign position.
    for (int j = 0; j < WE; j++) begin
      pp[j] = (a_ext[j] & b_bit) ^ ((j == WE - 1) != last_row);
    end
    if (row >= IDX_W'(WE)) begin
      row_val = '0;
    end else begin
      row_val = {{WE{1'b0}}, pp} << row;
    end
  end

endmodule

// File: rtl/bw_mult_seq.sv
// rtl/bw_mult_seq.sv - sequential Baugh-Wooley WIDTH x WIDTH multiplier with handshakes
//
// Purpose: multiplies a by b (each independently signed or unsigned) by summing
//          ROWS_PER_CYC partial-product rows per clock into a 2*(WIDTH+1) accumulator.
// Ports:
//   clk        in   1        clock, rising edge
//   rst        in   1        synchronous active-high reset
//   in_valid   in   1        operands and modes valid
//   in_ready   out  1        engine accepts operands this cycle
//   a          in   WIDTH    multiplicand
//   b          in   WIDTH    multiplier
//   a_signed   in   1        a is two's complement
//   b_signed   in   1        b is two's complement
//   out_valid  out  1        p holds a finished product
//   out_ready  in   1        consumer takes p
//   p          out  2*WIDTH  product
module bw_mult_seq #(
  parameter int WIDTH        = 8,
  parameter int ROWS_PER_CYC = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               a_signed,
  input  logic               b_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);
  import bw_mult_pkg::*;

  localparam int WE    = WIDTH + 1;
  localparam int ACC_W = 2 * WE;
  localparam int NCYC  = ncyc(WIDTH, ROWS_PER_CYC);
  localparam int CNT_W = $clog2(WE + ROWS_PER_CYC);

  localparam logic [ACC_W-1:0] CORR     = ACC_W'(bw_corr(WE));
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((NCYC - 1) * ROWS_PER_CYC);
  localparam logic [CNT_W-1:0] STEP     = CNT_W'(ROWS_PER_CYC);

  state_t           state;
  logic [WE-1:0]    a_ext_q;
  logic [WE-1:0]    b_ext_q;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0] row_cnt;
  logic             accept;

  logic [ACC_W-1:0] row_val [ROWS_PER_CYC];

  assign in_ready = ~rst & ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  for (genvar k = 0; k < ROWS_PER_CYC; k++) begin : g_row
    logic [CNT_W-1:0] row_idx;
    logic             b_bit;

    assign row_idx = row_cnt + CNT_W'(k);
    // Shift rather than index so an out-of-range row simply selects 0.
    assign b_bit   = |((b_ext_q >> row_idx) & WE'(1));

    bw_pp_row #(
      .WE    (WE),
      .IDX_W (CNT_W)
    ) u_row (
      .a_ext   (a_ext_q),
      .b_bit   (b_bit),
      .row     (row_idx),
      .row_val (row_val[k])
    );
  end

  always_comb begin
    acc_sum = acc;
    for (int k = 0; k < ROWS_PER_CYC; k++) begin
      acc_sum = acc_sum + row_val[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      p         <= '0;
      acc       <= '0;
      row_cnt   <= '0;
      a_ext_q   <= '0;
      b_ext_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) state <= RUN;
        end
        RUN: begin
          acc     <= acc_sum;
          row_cnt <= row_cnt + STEP;
          if (row_cnt == LAST_CNT) begin
            p         <= acc_sum[2*WIDTH-1:0];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= in_valid ? RUN : IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Operand capture is shared by the IDLE accept and the back-to-back DONE accept.
      if (accept) begin
        a_ext_q <= {a_signed & a[WIDTH-1], a};
        b_ext_q <= {b_signed & b[WIDTH-1], b};
        acc     <= CORR;
        row_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bw_mult_seq.sv
// tb/tb_bw_mult_seq.sv - directed and randomised checks of bw_mult_seq
module tb_bw_mult_seq;

  logic clk;
  logic rst;

  // W=8, R=1 instance
  logic        in_valid, in_ready, a_signed, b_signed, out_valid, out_ready;
  logic [7:0]  a, b;
  logic [15:0] p;

  // W=8, R=3 instance
  logic        r3_in_valid, r3_in_ready, r3_a_signed, r3_b_signed, r3_out_valid, r3_out_ready;
  logic [7:0]  r3_a, r3_b;
  logic [15:0] r3_p;

  // W=16, R=17 instance
  logic        r17_in_valid, r17_in_ready, r17_a_signed, r17_b_signed, r17_out_valid, r17_out_ready;
  logic [15:0] r17_a, r17_b;
  logic [31:0] r17_p;

  int errors = 0;
  int checks = 0;

  bw_mult_seq #(.WIDTH(8), .ROWS_PER_CYC(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed),
    .out_valid(out_valid), .out_ready(out_ready), .p(p)
  );

  bw_mult_seq #(.WIDTH(8), .ROWS_PER_CYC(3)) dut_r3 (
    .clk(clk), .rst(rst), .in_valid(r3_in_valid), .in_ready(r3_in_ready),
    .a(r3_a), .b(r3_b), .a_signed(r3_a_signed), .b_signed(r3_b_signed),
    .out_valid(r3_out_valid), .out_ready(r3_out_ready), .p(r3_p)
  );

  bw_mult_seq #(.WIDTH(16), .ROWS_PER_CYC(17)) dut_r17 (
    .clk(clk), .rst(rst), .in_valid(r17_in_valid), .in_ready(r17_in_ready),
    .a(r17_a), .b(r17_b), .a_signed(r17_a_signed), .b_signed(r17_b_signed),
    .out_valid(r17_out_valid), .out_ready(r17_out_ready), .p(r17_p)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain integer product of the interpreted operands, reduced to 2*w bits.
  function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input int w, input bit sx, input bit sy);
    longint xv, yv, pr, m;
    xv = longint'(x);
    yv = longint'(y);
    if (sx && x[w-1]) xv = xv - (longint'(1) << w);
    if (sy && y[w-1]) yv = yv - (longint'(1) << w);
    pr = xv * yv;
    m  = (longint'(1) << (2 * w)) - 1;
    return 32'(pr & m);
  endfunction

  // Issue one operation on the W=8,R=1 instance from IDLE; returns p and the
  // number of edges from the accepting edge until out_valid (40 on timeout).
  task automatic run_mul(input logic [7:0] ta, input logic [7:0] tb, input bit sa, input bit sb,
                         output logic [15:0] pg, output int lat);
    @(negedge clk);
    a = ta; b = tb; a_signed = sa; b_signed = sb; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); a_signed = ~sa; b_signed = ~sb;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    pg = p;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low: got %b expected 0", in_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (p !== 16'h0000) begin errors++; $display("FAIL reset_p: got %h expected 0000", p); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_signed_min();
    logic [15:0] pg;
    int lat;
    run_mul(8'h80, 8'h80, 1'b1, 1'b1, pg, lat);
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL ss_min_latency: got %0d expected 9", lat); end
    checks++;
    if (pg !== 16'h4000) begin errors++; $display("FAIL ss_min_p: got %h expected 4000", pg); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL done_in_ready: got %b expected 0", in_ready); end
    consume();
  endtask

  task automatic test_modes();
    logic [15:0] pg;
    int lat;
    run_mul(8'hFF, 8'hFF, 1'b0, 1'b0, pg, lat);
    checks++;
    if (pg !== 16'hFE01 || lat !== 9) begin errors++; $display("FAIL uu_ff_ff: got p=%h lat=%0d expected p=fe01 lat=9", pg, lat); end
    consume();
    run_mul(8'hFF, 8'hFF, 1'b1, 1'b1, pg, lat);
    checks++;
    if (pg !== 16'h0001) begin errors++; $display("FAIL ss_ff_ff: got %h expected 0001", pg); end
    consume();
    run_mul(8'hFF, 8'hFF, 1'b1, 1'b0, pg, lat);
    checks++;
    if (pg !== 16'hFF01) begin errors++; $display("FAIL su_ff_ff: got %h expected ff01", pg); end
    consume();
    run_mul(8'h7F, 8'h02, 1'b1, 1'b0, pg, lat);
    checks++;
    if (pg !== 16'h00FE) begin errors++; $display("FAIL su_7f_02: got %h expected 00fe", pg); end
    consume();
    run_mul(8'h03, 8'h80, 1'b0, 1'b1, pg, lat);
    checks++;
    if (pg !== 16'hFE80) begin errors++; $display("FAIL us_03_80: got %h expected fe80", pg); end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [15:0] pg;
    int lat;
    run_mul(8'd5, 8'd6, 1'b0, 1'b0, pg, lat);
    checks++;
    if (pg !== 16'd30) begin errors++; $display("FAIL b2b_first_p: got %h expected 001e", pg); end
    a = 8'd7; b = 8'd8; a_signed = 1'b0; b_signed = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || p !== 16'd30) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got in_ready=%b out_valid=%b p=%h expected 0 1 001e", i, in_ready, out_valid, p);
      end
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b expected 1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    a = 8'hAA; b = 8'h55;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_out_valid_drop: got %b expected 0", out_valid); end
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    checks++;
    if (lat !== 9 || p !== 16'd56) begin errors++; $display("FAIL b2b_second: got p=%h lat=%0d expected p=0038 lat=9", p, lat); end
    consume();
  endtask

  task automatic test_mid_run_reset();
    logic [15:0] pg;
    int lat;
    @(negedge clk);
    a = 8'h12; b = 8'h34; a_signed = 1'b0; b_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || p !== 16'h0000 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_run_reset: got out_valid=%b p=%h in_ready=%b expected 0 0000 1", out_valid, p, in_ready);
    end
    repeat (12) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL discarded_product: got out_valid=%b expected 0", out_valid); end
    run_mul(8'h03, 8'hFB, 1'b1, 1'b1, pg, lat);
    checks++;
    if (pg !== 16'hFFF1 || lat !== 9) begin errors++; $display("FAIL after_reset_3x-5: got p=%h lat=%0d expected p=fff1 lat=9", pg, lat); end
    consume();
  endtask

  task automatic test_random_r3(input int n);
    logic [7:0]  ta, tb;
    bit          sa, sb, seen;
    logic [15:0] exp, got;
    int          cyc;
    for (int t = 0; t < n; t++) begin
      ta = 8'($urandom); tb = 8'($urandom); sa = 1'($urandom); sb = 1'($urandom);
      exp = 16'(model({8'h00, ta}, {8'h00, tb}, 8, sa, sb));
      @(negedge clk);
      r3_a = ta; r3_b = tb; r3_a_signed = sa; r3_b_signed = sb; r3_in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      r3_in_valid = 1'b0;
      seen = 1'b0; got = '0; cyc = 0;
      while (!seen && cyc < 100) begin
        r3_out_ready = 1'($urandom);
        #1;
        if (r3_out_valid && r3_out_ready) begin seen = 1'b1; got = r3_p; end
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
      r3_out_ready = 1'b0;
      checks++;
      if (!seen || got !== exp) begin
        errors++;
        $display("FAIL rand_r3 #%0d a=%h b=%h sa=%0d sb=%0d: got %h (seen=%0d) expected %h", t, ta, tb, sa, sb, got, seen, exp);
      end
    end
  endtask

  task automatic test_random_r17(input int n);
    logic [15:0] ta, tb;
    bit          sa, sb, seen;
    logic [31:0] exp, got;
    int          cyc;
    for (int t = 0; t < n; t++) begin
      ta = 16'($urandom); tb = 16'($urandom); sa = 1'($urandom); sb = 1'($urandom);
      exp = model(ta, tb, 16, sa, sb);
      @(negedge clk);
      r17_a = ta; r17_b = tb; r17_a_signed = sa; r17_b_signed = sb; r17_in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      r17_in_valid = 1'b0;
      seen = 1'b0; got = '0; cyc = 0;
      while (!seen && cyc < 100) begin
        r17_out_ready = 1'($urandom);
        #1;
        if (r17_out_valid && r17_out_ready) begin seen = 1'b1; got = r17_p; end
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
      r17_out_ready = 1'b0;
      checks++;
      if (!seen || got !== exp) begin
        errors++;
        $display("FAIL rand_r17 #%0d a=%h b=%h sa=%0d sb=%0d: got %h (seen=%0d) expected %h", t, ta, tb, sa, sb, got, seen, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; a_signed = 1'b0; b_signed = 1'b0; out_ready = 1'b0;
    r3_in_valid = 1'b0; r3_a = '0; r3_b = '0; r3_a_signed = 1'b0; r3_b_signed = 1'b0; r3_out_ready = 1'b0;
    r17_in_valid = 1'b0; r17_a = '0; r17_b = '0; r17_a_signed = 1'b0; r17_b_signed = 1'b0; r17_out_ready = 1'b0;

    test_reset();
    test_signed_min();
    test_modes();
    test_back_to_back();
    test_mid_run_reset();
    test_random_r3(300);
    test_random_r17(300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
